// File: rtl/uart_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_bus_master
// Description : Debug/boot bus initiator. Parses W/R/P command packets from
//               the UART RX byte stream, issues 32-bit transactions on the
//               FemtoRV-style memory bus and answers with ACK/NAK or the read
//               data on the UART TX byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_master #(
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        active,
    output logic        err_overrun
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ADDR    = 3'd1;
    localparam logic [2:0] c_ST_DATA    = 3'd2;
    localparam logic [2:0] c_ST_WR      = 3'd3;
    localparam logic [2:0] c_ST_RD_STB  = 3'd4;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd5;
    localparam logic [2:0] c_ST_TX      = 3'd6;
    localparam logic [2:0] c_ST_RESP    = 3'd7;

    localparam logic [7:0]  c_CMD_W        = 8'h57;
    localparam logic [7:0]  c_CMD_R        = 8'h52;
    localparam logic [7:0]  c_CMD_P        = 8'h50;
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic        r_is_write;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_resp;
    logic [31:0] r_timer;
    logic        w_timeout;

    assign w_timeout = (r_timer == c_TIMEOUT_LAST);
    // Word-aligned bus: the two low address bits are simply dropped.
    assign mem_addr  = r_addr & 32'hFFFF_FFFC;
    assign mem_wdata = r_wdata;
    assign active    = (r_state != c_ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state output drive
    always_comb begin
        w_state_next = r_state;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        mem_wmask    = 4'h0;
        mem_rstrb    = 1'b0;
        err_overrun  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == c_CMD_W || rx_data == c_CMD_R) begin
                        w_state_next = c_ST_ADDR;
                    end else begin
                        w_state_next = c_ST_RESP;
                    end
                end
            end
            c_ST_ADDR: begin
                if (rx_valid) begin
                    if (r_cnt == 2'd3) begin
                        w_state_next = r_is_write ? c_ST_DATA : c_ST_RD_STB;
                    end
                end else if (w_timeout) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_DATA: begin
                if (rx_valid) begin
                    if (r_cnt == 2'd3) begin
                        w_state_next = c_ST_WR;
                    end
                end else if (w_timeout) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_WR: begin
                mem_wmask   = 4'hF;
                err_overrun = rx_valid;
                if (!mem_wbusy) begin
                    w_state_next = c_ST_RESP;
                end
            end
            c_ST_RD_STB: begin
                mem_rstrb    = 1'b1;
                err_overrun  = rx_valid;
                w_state_next = c_ST_RD_WAIT;
            end
            c_ST_RD_WAIT: begin
                err_overrun = rx_valid;
                if (!mem_rbusy) begin
                    w_state_next = c_ST_TX;
                end
            end
            c_ST_TX: begin
                tx_valid    = 1'b1;
                err_overrun = rx_valid;
                case (r_cnt)
                    2'd0:    tx_data = r_rdata[7:0];
                    2'd1:    tx_data = r_rdata[15:8];
                    2'd2:    tx_data = r_rdata[23:16];
                    default: tx_data = r_rdata[31:24];
                endcase
                if (tx_ready && r_cnt == 2'd3) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_RESP: begin
                tx_valid    = 1'b1;
                tx_data     = r_resp;
                err_overrun = rx_valid;
                if (tx_ready) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Packet assembly, inter-byte timer, read capture and byte counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_write <= 1'b0;
            r_cnt      <= 2'd0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_resp     <= 8'h00;
            r_timer    <= 32'h0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (rx_valid) begin
                        r_cnt      <= 2'd0;
                        r_timer    <= 32'h0;
                        r_is_write <= (rx_data == c_CMD_W);
                        r_resp     <= (rx_data == c_CMD_P) ? ACK_BYTE : NAK_BYTE;
                    end
                end
                c_ST_ADDR: begin
                    if (rx_valid) begin
                        // LSB arrives first, so shift in from the top.
                        r_addr  <= {rx_data, r_addr[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        r_timer <= 32'h0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                c_ST_DATA: begin
                    if (rx_valid) begin
                        r_wdata <= {rx_data, r_wdata[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        r_timer <= 32'h0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                c_ST_WR: begin
                    if (!mem_wbusy) begin
                        r_resp <= ACK_BYTE;
                    end
                end
                c_ST_RD_WAIT: begin
                    if (!mem_rbusy) begin
                        r_rdata <= mem_rdata;
                        r_cnt   <= 2'd0;
                    end
                end
                c_ST_TX: begin
                    if (tx_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_bus_master
// Description : Self-checking bench for uart_bus_master: directed packet
//               table, timeout / reset corner sequences and random packets
//               checked against a word-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_master;

    localparam int c_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic        active;
    logic        err_overrun;

    always #5 clk = ~clk;

    uart_bus_master #(
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_rstrb   (mem_rstrb),
        .mem_rdata   (mem_rdata),
        .mem_rbusy   (mem_rbusy),
        .mem_wbusy   (mem_wbusy),
        .active      (active),
        .err_overrun (err_overrun)
    );

    // ---------------- bus responder: 256-word memory, 1-cycle read latency
    logic [31:0] rsp_mem [0:255];
    logic [31:0] r_rsp_rdata;
    int          r_wcnt;
    int          wbusy_len;
    bit          rbusy_force;

    function automatic logic [31:0] f_init(input int i);
        if (i == 1) return 32'h1234_5678;
        return {8'hA5, 8'(i), ~8'(i), 8'h3C};
    endfunction

    assign mem_rdata = r_rsp_rdata;
    assign mem_rbusy = rbusy_force;
    assign mem_wbusy = (mem_wmask == 4'hF) && (r_wcnt < wbusy_len);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) rsp_mem[i] <= f_init(i);
            r_wcnt      <= 0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_wcnt <= (mem_wmask == 4'hF) ? r_wcnt + 1 : 0;
            if (mem_wmask == 4'hF && !mem_wbusy) rsp_mem[mem_addr[9:2]] <= mem_wdata;
            if (mem_rstrb) r_rsp_rdata <= rsp_mem[mem_addr[9:2]];
        end
    end

    // ---------------- bus / stream monitor
    logic [7:0]  tx_log [$];
    logic [63:0] wr_log [$];
    int          rd_cnt = 0;
    int          mask_cycles = 0;
    int          err_cnt = 0;
    int          viol = 0;
    int          txv_cycles = 0;
    logic [31:0] rd_addr_last = 32'h0;
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_reset = 1'b1;
    logic [7:0]  p_data = 8'h00;

    always @(posedge clk) begin
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (tx_valid) txv_cycles <= txv_cycles + 1;
        if (mem_rstrb) begin
            rd_cnt       <= rd_cnt + 1;
            rd_addr_last <= mem_addr;
        end
        if (mem_wmask != 4'h0) mask_cycles <= mask_cycles + 1;
        if (mem_wmask == 4'hF && !mem_wbusy) wr_log.push_back({mem_addr, mem_wdata});
        if (err_overrun) err_cnt <= err_cnt + 1;
        if ((mem_wmask != 4'h0 && mem_wmask != 4'hF) || mem_addr[1:0] != 2'b00 ||
            (tx_valid && !active))
            viol <= viol + 1;
        else if (p_valid && !p_ready && !p_reset && (!tx_valid || tx_data != p_data))
            viol <= viol + 1;
        p_valid <= tx_valid;
        p_ready <= tx_ready;
        p_reset <= reset;
        p_data  <= tx_data;
    end

    // ---------------- checking helpers
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_ctrl"}, {tx_valid, tx_data, mem_wmask, mem_rstrb, active, err_overrun}, 0);
    endtask

    // ---------------- reference model: word memory seen through addr[9:2]
    logic [31:0] model_mem [0:255];

    task automatic model_init();
        for (int i = 0; i < 256; i++) model_mem[i] = f_init(i);
    endtask

    typedef struct {
        logic [71:0] pkt;       // byte i at [8i+:8]
        int          len;
        int          wbusy;
        int          gap;       // tx_ready withheld this many cycles per byte
        bit          inject;    // push an extra rx byte while tx is pending
        logic [31:0] exp_tx;    // expected tx bytes, first byte in [7:0]
        int          exp_ntx;
        int          exp_rd;
        logic [31:0] exp_rd_addr;
        int          exp_wr;
        logic [63:0] exp_wr_ent;
        int          exp_mask;
        int          exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [71:0] pkt, input int len, input int wbusy,
                                input int gap, input bit inject, input logic [31:0] exp_tx,
                                input int ntx, input int rd, input logic [31:0] rd_addr,
                                input int wr, input logic [63:0] wr_ent, input int mask,
                                input int err);
        vec_t v;
        v.pkt = pkt; v.len = len; v.wbusy = wbusy; v.gap = gap; v.inject = inject;
        v.exp_tx = exp_tx; v.exp_ntx = ntx; v.exp_rd = rd; v.exp_rd_addr = rd_addr;
        v.exp_wr = wr; v.exp_wr_ent = wr_ent; v.exp_mask = mask; v.exp_err = err;
        return v;
    endfunction

    task automatic make_rand(output vec_t v);
        int          typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  cmd;
        typ  = $urandom_range(0, 3);
        addr = $urandom;
        data = $urandom;
        v = mk(72'h0, 1, $urandom_range(0, 4), $urandom_range(0, 3), 1'b0,
               32'h06, 1, 0, 32'h0, 0, 64'h0, 0, 0);
        case (typ)
            0: v.pkt = 72'h50;
            1: begin
                cmd = 8'(($urandom_range(0, 255)));
                while (cmd == 8'h57 || cmd == 8'h52 || cmd == 8'h50) cmd = cmd + 8'd1;
                v.pkt    = {64'h0, cmd};
                v.exp_tx = 32'h15;
            end
            2: begin
                v.pkt        = {data, addr, 8'h57};
                v.len        = 9;
                v.exp_wr     = 1;
                v.exp_wr_ent = {addr & 32'hFFFF_FFFC, data};
                v.exp_mask   = v.wbusy + 1;
            end
            default: begin
                v.pkt         = {32'h0, addr, 8'h52};
                v.len         = 5;
                v.exp_tx      = model_mem[addr[9:2]];
                v.exp_ntx     = 4;
                v.exp_rd      = 1;
                v.exp_rd_addr = addr & 32'hFFFF_FFFC;
                v.inject      = ($urandom_range(0, 3) == 0);
                v.exp_err     = v.inject ? 1 : 0;
            end
        endcase
    endtask

    // Send one packet, service the tx side until the block goes idle, compare.
    task automatic apply(input vec_t v, input int between_max);
        int tx_base, rd_base, wr_base, mask_base, err_base, hold, ntx;
        bit done, injected;
        logic [31:0] exp_tx;
        tx_base   = tx_log.size();
        wr_base   = wr_log.size();
        rd_base   = rd_cnt;
        mask_base = mask_cycles;
        err_base  = err_cnt;
        wbusy_len = v.wbusy;
        for (int i = 0; i < v.len; i++) begin
            rx_valid = 1'b1;
            rx_data  = v.pkt[8*i +: 8];
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (i == 0) check("active_after_cmd", active, 1);
            if (i < v.len - 1) repeat ($urandom_range(0, between_max)) begin
                @(posedge clk); #1;
            end
        end
        done = 1'b0; hold = 0; injected = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!active) begin
                done = 1'b1;
                break;
            end
            if (tx_valid) begin
                if (hold < v.gap) begin tx_ready = 1'b0; hold++; end
                else begin tx_ready = 1'b1; hold = 0; end
            end else begin
                tx_ready = 1'b0;
            end
            if (v.inject && tx_valid && !injected) begin
                rx_valid = 1'b1; rx_data = 8'h41; injected = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        check("pkt_done", done, 1);
        check("idle_no_tx_valid", tx_valid, 0);
        ntx = tx_log.size() - tx_base;
        check("tx_count", ntx, v.exp_ntx);
        exp_tx = v.exp_tx;
        for (int k = 0; k < v.exp_ntx && k < ntx; k++)
            check("tx_byte", tx_log[tx_base + k], exp_tx[8*k +: 8]);
        check("rd_strobes", rd_cnt - rd_base, v.exp_rd);
        if (v.exp_rd > 0) check("rd_addr", rd_addr_last, v.exp_rd_addr);
        check("wr_count", wr_log.size() - wr_base, v.exp_wr);
        if (v.exp_wr > 0 && wr_log.size() > wr_base) begin
            check("wr_addr_data", wr_log[wr_base], v.exp_wr_ent);
            model_mem[v.exp_wr_ent[41:34]] = v.exp_wr_ent[31:0];
        end
        check("mask_cycles", mask_cycles - mask_base, v.exp_mask);
        check("err_pulses", err_cnt - err_base, v.exp_err);
        check("protocol_viol", viol, 0);
    endtask

    vec_t tbl [6];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   tx_base, txv_base;
        logic [39:0] rd_pkt;

        tbl[0] = mk(72'h50, 1, 0, 0, 1'b0, 32'h06, 1, 0, 32'h0, 0, 64'h0, 0, 0);
        tbl[1] = mk(72'hAA, 1, 0, 1, 1'b0, 32'h15, 1, 0, 32'h0, 0, 64'h0, 0, 0);
        tbl[2] = mk({8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h10, 8'h00, 8'h57}, 9, 3, 2,
                    1'b0, 32'h06, 1, 0, 32'h0, 1, {32'h0000_1000, 32'hDEAD_BEEF}, 4, 0);
        tbl[3] = mk({32'h0, 8'h00, 8'h00, 8'h10, 8'h04, 8'h52}, 5, 0, 5, 1'b0,
                    32'h1234_5678, 4, 1, 32'h0000_1004, 0, 64'h0, 0, 0);
        tbl[4] = mk({32'h0, 8'h00, 8'h00, 8'h10, 8'h03, 8'h52}, 5, 0, 1, 1'b0,
                    32'hDEAD_BEEF, 4, 1, 32'h0000_1000, 0, 64'h0, 0, 0);
        tbl[5] = mk({32'h0, 8'h00, 8'h00, 8'h10, 8'h04, 8'h52}, 5, 0, 2, 1'b1,
                    32'h1234_5678, 4, 1, 32'h0000_1004, 0, 64'h0, 0, 1);

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        wbusy_len = 0; rbusy_force = 1'b0;
        model_init();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++) apply(tbl[i], 0);

        // Partial write packet followed by silence is discarded after the timeout.
        tx_base  = tx_log.size();
        txv_base = txv_cycles;
        tx_ready = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h57;
        @(posedge clk); #1;
        rx_data = 8'h00;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        for (int k = 1; k <= c_TIMEOUT; k++) begin
            @(posedge clk); #1;
            if (k == c_TIMEOUT - 1) check("timeout_still_active", active, 1);
            if (k == c_TIMEOUT)     check("timeout_idle", active, 0);
        end
        tx_ready = 1'b0;
        check("timeout_no_tx", tx_log.size() - tx_base, 0);
        check("timeout_no_tx_valid", txv_cycles - txv_base, 0);
        apply(tbl[0], 0);

        // Reset while the read is stalled waiting on the bus.
        rbusy_force = 1'b1;
        rd_pkt = {8'h00, 8'h00, 8'h10, 8'h00, 8'h52};
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = rd_pkt[8*i +: 8];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check("stall_rstrb", mem_rstrb, 1);
        @(posedge clk); #1;
        check("stall_wait", {mem_rstrb, active}, 2'b01);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rbusy_force = 1'b0;
        check_all_zero("midreset");
        model_init();
        apply(tbl[0], 0);

        for (int n = 0; n < 40; n++) begin
            make_rand(v);
            apply(v, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
